// File: rtl/output_neuron_pkg.sv
// Shared widths, saturation limits and FSM states for the output neuron.
// Imported by mac_sat and output_forward.
package output_neuron_pkg;

    localparam int HIDDEN_W = 10;
    localparam int WEIGHT_W = 8;
    localparam int FINAL_W  = 23;
    localparam int PROD_W   = HIDDEN_W + 1 + WEIGHT_W;
    localparam int SUM_W    = FINAL_W + 1;

    localparam logic signed [FINAL_W-1:0] FINAL_MAX =
        {1'b0, {(FINAL_W-1){1'b1}}};
    localparam logic signed [FINAL_W-1:0] FINAL_MIN =
        {1'b1, {(FINAL_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } fwd_state_t;

    // Clamp a signed result at zero.
    function automatic logic [FINAL_W-1:0] relu(
        input logic [FINAL_W-1:0] v
    );
        return v[FINAL_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/mac_sat.sv
// Combinational multiply-accumulate with saturation to the signed final width.
// Ports: acc_i (signed acc), hidden_i (unsigned), w_i (signed), sum_o (sat sum).
module mac_sat
    import output_neuron_pkg::*;
(
    input  logic [FINAL_W-1:0]  acc_i,
    input  logic [HIDDEN_W-1:0] hidden_i,
    input  logic [WEIGHT_W-1:0] w_i,
    output logic [FINAL_W-1:0]  sum_o
);

    logic signed [PROD_W-1:0] h_ext;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] prod;
    logic        [SUM_W-1:0]  sum;

    always_comb begin
        // Hidden value is unsigned: zero-extend; weight sign-extends.
        h_ext = {{(PROD_W-HIDDEN_W){1'b0}}, hidden_i};
        w_ext = {{(PROD_W-WEIGHT_W){w_i[WEIGHT_W-1]}}, w_i};
        prod  = h_ext * w_ext;
        sum   = {acc_i[FINAL_W-1], acc_i}
              + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
        // Top two bits disagree -> result left the 23-bit range.
        if (sum[SUM_W-1] != sum[SUM_W-2]) begin
            sum_o = sum[SUM_W-1] ? FINAL_MIN : FINAL_MAX;
        end else begin
            sum_o = sum[FINAL_W-1:0];
        end
    end

endmodule

// File: rtl/output_forward.sv
// Output-layer forward pass: accumulates N_HIDDEN hidden*weight beats.
// Ports: clk_i, rst_i (async low), en_i, start_i, valid_i, hidden_val_i,
//   w_i, ack_i, zero_weight_reset_i -> final_o, f_end_o, busy_o.
// Option: OUTPUT_FORWARD_RELU_EN clamps the loaded final_o at zero.
module output_forward
    import output_neuron_pkg::*;
#(
    parameter int N_HIDDEN = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                start_i,
    input  logic                valid_i,
    input  logic [HIDDEN_W-1:0] hidden_val_i,
    input  logic [WEIGHT_W-1:0] w_i,
    input  logic                ack_i,
    input  logic                zero_weight_reset_i,
    output logic [FINAL_W-1:0]  final_o,
    output logic                f_end_o,
    output logic                busy_o
);

    localparam int CNT_W = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_HIDDEN - 1);

    fwd_state_t         state;
    logic [FINAL_W-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [FINAL_W-1:0] mac_sum;
    logic [FINAL_W-1:0] final_d;
    logic               beat;

    mac_sat u_mac (
        .acc_i    (acc),
        .hidden_i (hidden_val_i),
        .w_i      (w_i),
        .sum_o    (mac_sum)
    );

    assign beat = en_i & valid_i;

    always_comb begin
`ifdef OUTPUT_FORWARD_RELU_EN
        final_d = relu(mac_sum);
`else
        final_d = mac_sum;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            acc     <= '0;
            cnt     <= '0;
            final_o <= '0;
            f_end_o <= 1'b0;
            busy_o  <= 1'b0;
        end else if (zero_weight_reset_i) begin
            state   <= S_IDLE;
            acc     <= '0;
            cnt     <= '0;
            final_o <= '0;
            f_end_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_i && en_i) begin
                        state  <= S_ACCUM;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (beat) begin
                        acc <= mac_sum;
                        if (cnt == LAST) begin
                            state   <= S_DONE;
                            final_o <= final_d;
                            f_end_o <= 1'b1;
                            busy_o  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // start_i alongside ack_i only returns to idle.
                    if (ack_i) begin
                        state   <= S_IDLE;
                        f_end_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    f_end_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_forward.sv
// Directed bench for output_forward (N_HIDDEN=4 and N_HIDDEN=64 instances).
// Honours OUTPUT_FORWARD_RELU_EN when computing expected outputs.
module tb_output_forward;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        start4 = 1'b0;
    logic        start64 = 1'b0;
    logic        valid = 1'b0;
    logic [9:0]  hid = '0;
    logic [7:0]  w = '0;
    logic        ack = 1'b0;
    logic        zwr = 1'b0;
    logic [22:0] fin4, fin64;
    logic        fend4, fend64, busy4, busy64;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    output_forward #(.N_HIDDEN(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start4),
        .valid_i(valid), .hidden_val_i(hid), .w_i(w), .ack_i(ack),
        .zero_weight_reset_i(zwr), .final_o(fin4), .f_end_o(fend4),
        .busy_o(busy4)
    );

    output_forward #(.N_HIDDEN(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start64),
        .valid_i(valid), .hidden_val_i(hid), .w_i(w), .ack_i(ack),
        .zero_weight_reset_i(zwr), .final_o(fin64), .f_end_o(fend64),
        .busy_o(busy64)
    );

    typedef struct {
        logic [3:0][9:0] h;
        logic [3:0][7:0] wt;
        int              exp;
        string           name;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    function automatic int model_out(input int v);
`ifdef OUTPUT_FORWARD_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int s23(input logic [22:0] v);
        return int'($signed(v));
    endfunction

    task automatic start_pass4();
        start4 = 1'b1;
        en = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    task automatic beat(input logic [9:0] h, input logic [7:0] wt);
        valid = 1'b1;
        hid = h;
        w = wt;
        tick();
        valid = 1'b0;
    endtask

    task automatic ack_done(input string nm, input int want);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({nm, ".fend_after_ack"}, int'(fend4), 0);
        chk({nm, ".final_kept"}, s23(fin4), want);
    endtask

    initial begin
        vecs[0] = '{h: '{10'd4, 10'd3, 10'd2, 10'd1},
                    wt: '{8'd1, 8'd1, 8'd1, 8'd1},
                    exp: 10, name: "seq1234"};
        vecs[1] = '{h: '{10'd1023, 10'd1023, 10'd1023, 10'd1023},
                    wt: '{8'h80, 8'h80, 8'h80, 8'h80},
                    exp: -523776, name: "maxneg"};
        vecs[2] = '{h: '{10'd5, 10'd5, 10'd5, 10'd5},
                    wt: '{8'd2, 8'd2, 8'd2, 8'd2},
                    exp: 40, name: "fivetwo"};
        vecs[3] = '{h: '{10'd1023, 10'd1023, 10'd1023, 10'd1023},
                    wt: '{8'd127, 8'd127, 8'd127, 8'd127},
                    exp: 519684, name: "maxpos"};
        vecs[4] = '{h: '{10'd400, 10'd300, 10'd200, 10'd100},
                    wt: '{8'hFF, 8'd1, 8'hFE, 8'd3},
                    exp: -200, name: "mixed"};
        vecs[5] = '{h: '{10'd0, 10'd0, 10'd0, 10'd0},
                    wt: '{8'h80, 8'h80, 8'h80, 8'h80},
                    exp: 0, name: "zerohid"};

        // Reset state.
        repeat (2) tick();
        chk("rst.final", s23(fin4), 0);
        chk("rst.fend", int'(fend4), 0);
        chk("rst.busy", int'(busy4), 0);
        rst = 1'b1;
        tick();

        // Table-driven 4-beat passes.
        foreach (vecs[k]) begin
            start_pass4();
            chk({vecs[k].name, ".busy"}, int'(busy4), 1);
            for (int i = 0; i < 4; i++) begin
                if (i == 3)
                    chk({vecs[k].name, ".fend_early"}, int'(fend4), 0);
                beat(vecs[k].h[i], vecs[k].wt[i]);
            end
            chk({vecs[k].name, ".fend"}, int'(fend4), 1);
            chk({vecs[k].name, ".final"}, s23(fin4),
                model_out(vecs[k].exp));
            ack_done(vecs[k].name, model_out(vecs[k].exp));
        end

        // Pause with en low, plus ignored valid in IDLE and start in ACCUM.
        valid = 1'b1; hid = 10'd777; w = 8'd5;
        tick();
        start_pass4();
        valid = 1'b0;
        beat(10'd1, 8'd1);
        beat(10'd2, 8'd1);
        en = 1'b0;
        valid = 1'b1; hid = 10'd999; w = 8'd7;
        repeat (3) tick();
        chk("pause.busy", int'(busy4), 1);
        chk("pause.fend", int'(fend4), 0);
        en = 1'b1;
        start4 = 1'b1;
        beat(10'd3, 8'd1);
        start4 = 1'b0;
        beat(10'd4, 8'd1);
        chk("pause.fend_done", int'(fend4), 1);
        chk("pause.final", s23(fin4), 10);

        // Hold in DONE for 10 cycles, then ack with start also high.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold.fend", int'(fend4), 1);
            chk("hold.final", s23(fin4), 10);
        end
        ack = 1'b1;
        start4 = 1'b1;
        tick();
        ack = 1'b0;
        start4 = 1'b0;
        chk("ackstart.fend", int'(fend4), 0);
        chk("ackstart.busy", int'(busy4), 0);
        tick();
        chk("ackstart.still_idle", int'(busy4), 0);

        // Async reset mid-pass.
        start_pass4();
        beat(10'd100, 8'd3);
        beat(10'd100, 8'd3);
        #2 rst = 1'b0;
        #1;
        chk("arst.final", s23(fin4), 0);
        chk("arst.busy", int'(busy4), 0);
        chk("arst.fend", int'(fend4), 0);
        tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("arst.no_fend", int'(fend4), 0);
        start_pass4();
        for (int i = 0; i < 4; i++) beat(10'd5, 8'd2);
        chk("arst.fend", int'(fend4), 1);
        chk("arst.final_after", s23(fin4), 40);
        ack_done("arst", 40);

        // Synchronous clear mid-ACCUM and in DONE.
        start_pass4();
        beat(10'd9, 8'd9);
        zwr = 1'b1;
        valid = 1'b1;
        tick();
        zwr = 1'b0;
        valid = 1'b0;
        chk("zwr.busy", int'(busy4), 0);
        chk("zwr.final", s23(fin4), 0);
        start_pass4();
        for (int i = 0; i < 4; i++) beat(10'd10, 8'd10);
        chk("zwr.pass", s23(fin4), 400);
        zwr = 1'b1;
        tick();
        zwr = 1'b0;
        chk("zwr.done_fend", int'(fend4), 0);
        chk("zwr.done_final", s23(fin4), 0);

        // 64-beat saturation, negative then positive.
        for (int p = 0; p < 2; p++) begin
            start64 = 1'b1;
            en = 1'b1;
            tick();
            start64 = 1'b0;
            for (int i = 0; i < 64; i++)
                beat(10'd1023, (p == 0) ? 8'h80 : 8'd127);
            chk("sat.fend", int'(fend64), 1);
            chk(p == 0 ? "sat.neg" : "sat.pos", s23(fin64),
                model_out(p == 0 ? -4194304 : 4194303));
            ack = 1'b1;
            tick();
            ack = 1'b0;
            chk("sat.fend_ack", int'(fend64), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
